// File: rtl/ahp_master_pkg.sv
// Shared AHB-Lite encodings for the master/slave pair.
// Transfer types, size codes, response codes and the byte-lane helper.
package ahp_master_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE    = 2'b00,
        HTRANS_BUSY    = 2'b01,
        HTRANS_NON_SEQ = 2'b10,
        HTRANS_SEQ     = 2'b11
    } htrans_e;

    typedef enum logic {
        RESP_OKAY  = 1'b0,
        RESP_ERROR = 1'b1
    } hresp_e;

    localparam logic [2:0] SIZE_BYTE = 3'b000;
    localparam logic [2:0] SIZE_HALF = 3'b001;
    localparam logic [2:0] SIZE_WORD = 3'b010;

    // Byte lanes touched by a write; unknown sizes act as a full word.
    function automatic logic [3:0] lane_en(
        input logic [2:0] size,
        input logic [1:0] lo
    );
        logic [3:0] be;
        be = 4'b1111;
        if (size == SIZE_BYTE)
            be = 4'b0001 << lo;
        else if (size == SIZE_HALF)
            be = lo[1] ? 4'b1100 : 4'b0011;
        else if (size == SIZE_WORD)
            be = 4'b1111;
        return be;
    endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Word-organised SRAM with per-byte write enables.
// Read is asynchronous so the slave can present data in the same cycle.
module ahb_sram_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Byte-masked write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with configurable wait states.
// Define AHB_SLAVE_ERROR_EN to enable the two-cycle ERROR response.
module ahb_sram_slave
    import ahp_master_pkg::*;
#(
    parameter int          DEPTH       = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] IDLE_ST = 3'd0;
    localparam logic [2:0] WAIT_ST = 3'd1;
    localparam logic [2:0] DATA_ST = 3'd2;
    localparam logic [2:0] ERR1_ST = 3'd3;
    localparam logic [2:0] ERR2_ST = 3'd4;

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    logic [2:0]    state;
    logic [2:0]    cnt;
    logic [31:0]   addr_q;
    logic          write_q;
    logic [2:0]    size_q;
    logic          active_q;
    logic [31:0]   hold_q;

    logic          cap;
    logic          err;
    logic [2:0]    cap_nxt;
    logic [31:0]   off_q;
    logic [AW-1:0] idx;
    logic [31:0]   rdata;
    logic          we;
    logic          rd_phase;
    logic          unused_ok;

    assign cap = HSEL & HREADY & HTRANS[1]
               & ((state == IDLE_ST) | (state == DATA_ST));

`ifdef AHB_SLAVE_ERROR_EN
    logic [32:0] off_a;
    assign off_a = {1'b0, HADDR} - {1'b0, BASE_ADDR};
    assign err = (off_a >= 33'(4 * DEPTH))
               | (HSIZE > SIZE_WORD)
               | ((HSIZE == SIZE_HALF) & HADDR[0])
               | ((HSIZE == SIZE_WORD) & (|HADDR[1:0]));
    assign cap_nxt = err ? ERR1_ST
                   : ((WS != 3'd0) ? WAIT_ST : DATA_ST);
`else
    assign err = 1'b0;
    assign cap_nxt = (WS != 3'd0) ? WAIT_ST : DATA_ST;
`endif

    // Address-phase capture of the transfer attributes.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= '0;
            active_q <= 1'b0;
        end else if (cap) begin
            addr_q   <= HADDR;
            write_q  <= HWRITE;
            size_q   <= HSIZE;
            active_q <= 1'b1;
        end else if (HREADYOUT) begin
            active_q <= 1'b0;
        end
    end

    // Data-phase sequencing: waits, data, error pair.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= IDLE_ST;
            cnt   <= '0;
        end else begin
            if (cap)
                cnt <= WS;
            unique case (state)
                IDLE_ST: if (cap) state <= cap_nxt;
                WAIT_ST: begin
                    if (cnt <= 3'd1)
                        state <= DATA_ST;
                    else
                        cnt <= cnt - 3'd1;
                end
                DATA_ST: state <= cap ? cap_nxt : IDLE_ST;
                ERR1_ST: state <= ERR2_ST;
                ERR2_ST: state <= IDLE_ST;
                default: state <= IDLE_ST;
            endcase
        end
    end

    assign off_q    = addr_q - BASE_ADDR;
    assign idx      = off_q[AW+1:2];
    assign we       = (state == DATA_ST) & active_q & write_q;
    assign rd_phase = (state == DATA_ST) & active_q & ~write_q;

    ahb_sram_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (HCLK),
        .we    (we),
        .be    (lane_en(size_q, addr_q[1:0])),
        .addr  (idx),
        .wdata (HWDATA),
        .rdata (rdata)
    );

    // Keep the last read word visible outside read data phases.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            hold_q <= '0;
        else if (rd_phase)
            hold_q <= rdata;
    end

    assign HRDATA    = rd_phase ? rdata : hold_q;
    assign HREADYOUT = ~((state == WAIT_ST) | (state == ERR1_ST));

`ifdef AHB_SLAVE_ERROR_EN
    assign HRESP = ((state == ERR1_ST) | (state == ERR2_ST))
                 ? RESP_ERROR : RESP_OKAY;
`else
    assign HRESP = RESP_OKAY;
`endif

    assign unused_ok = ^{HBURST, HTRANS[0], off_q, err};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Randomised bench for ahb_sram_slave against an array model.
// Runs a zero-wait instance and a two-wait instance side by side.
module tb_ahb_sram_slave;

    logic        clk = 1'b0;
    logic [1:0]  rst_n;
    logic [1:0]  hsel;
    logic [1:0]  hwrite;
    logic [31:0] haddr  [2];
    logic [2:0]  hsize  [2];
    logic [1:0]  htrans [2];
    logic [31:0] hwdata [2];
    logic [31:0] hrdata [2];
    logic [1:0]  rdy;
    logic [1:0]  resp;
    logic [2:0]  hburst = 3'b000;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem_m [2][256];

    logic        p_wr [8];
    logic [31:0] p_a  [8];
    logic [2:0]  p_sz [8];
    logic [31:0] p_wd [8];

    always #5 clk = ~clk;

    ahb_sram_slave #(.WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESETn(rst_n[0]), .HSEL(hsel[0]),
        .HADDR(haddr[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]),
        .HBURST(hburst), .HTRANS(htrans[0]), .HWDATA(hwdata[0]),
        .HREADY(rdy[0]), .HREADYOUT(rdy[0]), .HRESP(resp[0]),
        .HRDATA(hrdata[0])
    );

    ahb_sram_slave #(.WAIT_STATES(2)) dut1 (
        .HCLK(clk), .HRESETn(rst_n[1]), .HSEL(hsel[1]),
        .HADDR(haddr[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]),
        .HBURST(hburst), .HTRANS(htrans[1]), .HWDATA(hwdata[1]),
        .HREADY(rdy[1]), .HREADYOUT(rdy[1]), .HRESP(resp[1]),
        .HRDATA(hrdata[1])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit m_err(input logic [31:0] a, input logic [2:0] sz);
`ifdef AHB_SLAVE_ERROR_EN
        return (a >= 32'd1024) || (sz > 3'd2)
            || (sz == 3'd1 && (a % 2) != 0)
            || (sz == 3'd2 && (a % 4) != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a / 4) % 256);
    endfunction

    function automatic bit lane_hit(input logic [2:0] sz,
                                    input logic [31:0] a, input int b);
        if (sz == 3'd0) return b == int'(a % 4);
        if (sz == 3'd1) return (b / 2) == int'((a / 2) % 2);
        return 1'b1;
    endfunction

    task automatic m_wr(input int d, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] wd);
        int i;
        i = m_idx(a);
        for (int b = 0; b < 4; b++)
            if (lane_hit(sz, a, b))
                mem_m[d][i][8*b +: 8] = wd[8*b +: 8];
    endtask

    task automatic bus_idle(input int d);
        hsel[d]   = 1'b0;
        htrans[d] = 2'b00;
        hwrite[d] = 1'b0;
    endtask

    task automatic xfer(input int d, input logic wr, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] wd,
                        input string tag);
        int   n;
        bit   e;
        logic lowr;
        e = m_err(a, sz);
        @(posedge clk); #1;
        hsel[d] = 1'b1; htrans[d] = 2'b10; hwrite[d] = wr;
        haddr[d] = a; hsize[d] = sz;
        @(posedge clk); #1;
        bus_idle(d);
        hwdata[d] = wd;
        n = 0;
        lowr = 1'b0;
        while (rdy[d] == 1'b0 && n < 20) begin
            lowr = lowr | resp[d];
            n++;
            @(posedge clk); #1;
        end
        check({tag, ".waits"}, 32'(n), e ? 32'd1 : (d == 1 ? 32'd2 : 32'd0));
        check({tag, ".lowresp"}, 32'(lowr), 32'(e));
        check({tag, ".resp"}, 32'(resp[d]), 32'(e));
        if (!e && !wr)
            check({tag, ".rdata"}, hrdata[d], mem_m[d][m_idx(a)]);
        if (!e && wr)
            m_wr(d, a, sz, wd);
    endtask

    task automatic pipe(input int n, input string tag);
        for (int i = 0; i <= n; i++) begin
            @(posedge clk); #1;
            if (i < n) begin
                hsel[0] = 1'b1;
                htrans[0] = (i == 0) ? 2'b10 : 2'b11;
                hwrite[0] = p_wr[i];
                haddr[0] = p_a[i];
                hsize[0] = p_sz[i];
            end else begin
                bus_idle(0);
            end
            if (i > 0) begin
                hwdata[0] = p_wd[i-1];
                check({tag, ".rdy"}, 32'(rdy[0]), 32'd1);
                if (p_wr[i-1])
                    m_wr(0, p_a[i-1], p_sz[i-1], p_wd[i-1]);
                else
                    check({tag, ".rd"}, hrdata[0], mem_m[0][m_idx(p_a[i-1])]);
            end
        end
    endtask

    function automatic logic [31:0] legal_addr(input int w, input logic [2:0] sz);
        int r;
        r = int'($urandom_range(0, 3));
        if (sz == 3'd0) return 32'(w * 4 + r);
        if (sz == 3'd1) return 32'(w * 4 + (r % 2) * 2);
        return 32'(w * 4);
    endfunction

    task automatic rand_xfer(input int d);
        int          k;
        int          w;
        logic [2:0]  sz;
        logic [31:0] a;
        k  = int'($urandom_range(0, 9));
        w  = int'($urandom_range(0, 63));
        sz = 3'($urandom_range(0, 2));
        a  = legal_addr(w, sz);
        if (k == 0) a = 32'h400 + a;
        if (k == 1) begin sz = 3'd2; a = 32'(w * 4 + 2); end
        if (k == 2) begin sz = 3'd1; a = 32'(w * 4 + 1); end
        if (k == 3) sz = 3'd3;
        xfer(d, 1'($urandom_range(0, 1)), a, sz, $urandom(), "rnd");
    endtask

    initial begin
        rst_n = 2'b00;
        for (int d = 0; d < 2; d++) begin
            bus_idle(d);
            haddr[d] = '0; hsize[d] = '0; hwdata[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 2'b11;
        for (int d = 0; d < 2; d++) begin
            check("rst.rdy", 32'(rdy[d]), 32'd1);
            check("rst.resp", 32'(resp[d]), 32'd0);
            check("rst.rdata", hrdata[d], 32'd0);
        end

        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 64; w++)
                xfer(d, 1'b1, 32'(w * 4), 3'd2, $urandom(), "pre");

        xfer(0, 1'b1, 32'h10, 3'd2, 32'hABCDEF23, "w10");
        xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, "r10");
        check("r10.const", hrdata[0], 32'hABCDEF23);

        xfer(0, 1'b1, 32'h20, 3'd2, 32'h0, "w20");
        xfer(0, 1'b1, 32'h21, 3'd0, 32'h0000_5600, "b21");
        xfer(0, 1'b1, 32'h22, 3'd1, 32'h12BC_0000, "h22");
        xfer(0, 1'b0, 32'h20, 3'd2, 32'h0, "r20");
        check("r20.const", hrdata[0], 32'h12BC5600);
        @(posedge clk); #1;
        check("hold", hrdata[0], 32'h12BC5600);

        xfer(1, 1'b1, 32'h10, 3'd2, 32'h5A5A_0F0F, "ws.w");
        xfer(1, 1'b0, 32'h10, 3'd2, 32'h0, "ws.r");
        check("ws.const", hrdata[1], 32'h5A5A_0F0F);

        xfer(0, 1'b1, 32'h400, 3'd2, 32'hFEED_BEEF, "e400");
        xfer(0, 1'b0, 32'h0, 3'd2, 32'h0, "r0");
        xfer(0, 1'b0, 32'h12, 3'd2, 32'h0, "e12");
        xfer(1, 1'b1, 32'h401, 3'd1, 32'h1234_5678, "e401");
        xfer(1, 1'b0, 32'h0, 3'd2, 32'h0, "r0b");

        @(posedge clk); #1;
        hsel[0] = 1'b1; htrans[0] = 2'b01; hwrite[0] = 1'b1;
        haddr[0] = 32'h10; hsize[0] = 3'd2;
        @(posedge clk); #1;
        bus_idle(0);
        hwdata[0] = 32'hDEAD_0001;
        check("busy.rdy", 32'(rdy[0]), 32'd1);
        check("busy.resp", 32'(resp[0]), 32'd0);
        @(posedge clk); #1;
        hsel[0] = 1'b0; htrans[0] = 2'b10; hwrite[0] = 1'b1;
        haddr[0] = 32'h10; hsize[0] = 3'd2;
        @(posedge clk); #1;
        bus_idle(0);
        hwdata[0] = 32'hDEAD_0002;
        check("nsel.rdy", 32'(rdy[0]), 32'd1);
        xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, "busy.r");
        check("busy.const", hrdata[0], 32'hABCDEF23);

        @(posedge clk); #1;
        hsel[1] = 1'b1; htrans[1] = 2'b10; hwrite[1] = 1'b1;
        haddr[1] = 32'h30; hsize[1] = 3'd2;
        @(posedge clk); #1;
        bus_idle(1);
        hwdata[1] = 32'hC0FF_EE00;
        rst_n[1] = 1'b0;
        #2;
        check("mrst.rdy", 32'(rdy[1]), 32'd1);
        check("mrst.rdata", hrdata[1], 32'd0);
        @(posedge clk); #1;
        rst_n[1] = 1'b1;
        xfer(1, 1'b0, 32'h30, 3'd2, 32'h0, "mrst.r");

        for (int i = 0; i < 4; i++) begin
            p_wr[i] = 1'b1; p_a[i] = 32'(32'h40 + i * 4);
            p_sz[i] = 3'd2; p_wd[i] = 32'(i + 1);
        end
        pipe(4, "bw");
        for (int i = 0; i < 4; i++) begin
            p_wr[i] = 1'b0; p_wd[i] = 32'h0;
        end
        pipe(4, "br");
        check("br.const", hrdata[0], 32'd4);

        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 6; i++) begin
                p_wr[i] = 1'($urandom_range(0, 1));
                p_sz[i] = 3'($urandom_range(0, 2));
                p_a[i]  = legal_addr(int'($urandom_range(0, 3)), p_sz[i]);
                p_wd[i] = $urandom();
            end
            pipe(6, "rp");
        end

        for (int i = 0; i < 80; i++) begin
            rand_xfer(0);
            rand_xfer(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
